// File: rtl/two_channel_note_sequencer.sv
// two_channel_note_sequencer
//
// Purpose: plays a 16-entry pattern of {duration, channel A period,
// channel B period} steps into a two-channel square wave generator at a
// programmable tempo, with optional looping. It needs no host CPU during
// playback. A period of 0 on either output means silence.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset (clears pattern memory)
//   wr_en      in   pattern write strobe, honoured only while idle
//   wr_addr    in   pattern entry index
//   wr_data    in   {dur[3:0], per_a[7:0], per_b[7:0]}
//   tick_div   in   cycles per tempo tick minus 1
//   last_step  in   index of the final step played
//   loop_en    in   1 = wrap to step 0 after last_step, 0 = stop
//   start      in   start request (level, idle only)
//   stop       in   abort request (level, beats start and step-end)
//   period_a   out  channel A half-period
//   period_b   out  channel B half-period
//   step       out  current or last fetched step index
//   busy       out  high while fetching or playing
//   done       out  one-cycle pulse when a non-looping sequence completes
module two_channel_note_sequencer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TICK_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [19:0]           wr_data,
  input  logic [TICK_WIDTH-1:0] tick_div,
  input  logic [DEPTH_LOG2-1:0] last_step,
  input  logic                  loop_en,
  input  logic                  start,
  input  logic                  stop,
  output logic [7:0]            period_a,
  output logic [7:0]            period_b,
  output logic [DEPTH_LOG2-1:0] step,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [19:0]           mem [DEPTH];
  logic [TICK_WIDTH-1:0] tick_div_sh;
  logic [DEPTH_LOG2-1:0] last_step_sh;
  logic                  loop_en_sh;
  logic [TICK_WIDTH-1:0] tick_cnt;
  logic [3:0]            dur_cnt;

  logic       start_ok;
  logic       step_end;
  logic       at_last;
  logic [19:0] entry;

  // Start is only accepted when stop is not also asserted.
  assign start_ok = start && !stop;
  // Both counters exhausted: this is the final PLAY cycle of the step.
  assign step_end = (state == PLAY) && (tick_cnt == '0) && (dur_cnt == '0);
  assign at_last  = (step == last_step_sh);
  assign entry    = mem[step];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        next_state = stop ? IDLE : PLAY;
      end
      PLAY: begin
        if (stop) begin
          next_state = IDLE;
        end else if (step_end) begin
          next_state = (!at_last || loop_en_sh) ? FETCH : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Pattern memory: writes are accepted only while idle, so a running
  // sequence can never see its pattern change underneath it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (state == IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Datapath: shadow configuration, step index, counters and the
  // registered period/done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_div_sh  <= '0;
      last_step_sh <= '0;
      loop_en_sh   <= 1'b0;
      tick_cnt     <= '0;
      dur_cnt      <= '0;
      step         <= '0;
      period_a     <= '0;
      period_b     <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            tick_div_sh  <= tick_div;
            last_step_sh <= last_step;
            loop_en_sh   <= loop_en;
            step         <= '0;
          end
        end
        FETCH: begin
          if (stop) begin
            period_a <= '0;
            period_b <= '0;
          end else begin
            period_a <= entry[15:8];
            period_b <= entry[7:0];
            dur_cnt  <= entry[19:16];
            tick_cnt <= tick_div_sh;
          end
        end
        PLAY: begin
          if (stop) begin
            period_a <= '0;
            period_b <= '0;
          end else if (tick_cnt != '0) begin
            tick_cnt <= tick_cnt - 1'b1;
          end else if (dur_cnt != '0) begin
            dur_cnt  <= dur_cnt - 1'b1;
            tick_cnt <= tick_div_sh;
          end else if (!at_last) begin
            step <= step + 1'b1;
          end else if (loop_en_sh) begin
            step <= '0;
          end else begin
            // Non-looping completion: silence and pulse done; step
            // keeps pointing at the last step played.
            period_a <= '0;
            period_b <= '0;
            done     <= 1'b1;
          end
        end
        default: begin
          period_a <= '0;
          period_b <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_two_channel_note_sequencer.sv
// tb_two_channel_note_sequencer
//
// Purpose: directed self-checking bench for two_channel_note_sequencer.
// Cycle c means "sampled 1 time unit after the c-th rising edge following
// the edge that sampled start" (c = 0 is that start edge).
module tb_two_channel_note_sequencer;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [19:0] wr_data;
  logic [15:0] tick_div;
  logic [3:0]  last_step;
  logic        loop_en;
  logic        start;
  logic        stop;
  logic [7:0]  period_a;
  logic [7:0]  period_b;
  logic [3:0]  step;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  two_channel_note_sequencer #(
    .DEPTH_LOG2(4),
    .TICK_WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .tick_div (tick_div),
    .last_step(last_step),
    .loop_en  (loop_en),
    .start    (start),
    .stop     (stop),
    .period_a (period_a),
    .period_b (period_b),
    .step     (step),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    tick_div  = '0;
    last_step = '0;
    loop_en   = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input logic [19:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    nextCycle();
    wr_en = 1'b0;
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_pa"}, 32'(period_a), 32'h0);
    checkOutput({tag, "_pb"}, 32'(period_b), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Start a last_step=0, tick_div=0 run of entry 0 and check it plays
  // the given periods for one step and then pulses done.
  task automatic runSingleStep(input string tag, input logic [7:0] pa,
                               input logic [7:0] pb);
    tick_div  = 16'd0;
    last_step = 4'd0;
    loop_en   = 1'b0;
    start     = 1'b1;
    nextCycle();
    clearInputs();
    checkOutput({tag, "_busy0"}, 32'(busy), 32'h1);
    nextCycle();
    checkOutput({tag, "_pa"}, 32'(period_a), 32'(pa));
    checkOutput({tag, "_pb"}, 32'(period_b), 32'(pb));
    nextCycle();
    checkOutput({tag, "_done"}, 32'(done), 32'h1);
    checkIdleZero({tag, "_end"});
    nextCycle();
    checkOutput({tag, "_done_clr"}, 32'(done), 32'h0);
  endtask

  // Three-step pattern, tick_div=3: step 0 spans cycles 1..9, step 1
  // 10..14, step 2 15..27 (its FETCH cycle in loop mode is 27).
  task automatic runPattern(input string tag, input logic loop, input int ncyc,
                            input logic inject);
    int p;
    int q;
    logic [7:0] epa;
    logic [7:0] epb;
    logic [3:0] estep;
    tick_div  = 16'd3;
    last_step = 4'd2;
    loop_en   = loop;
    start     = 1'b1;
    nextCycle();
    // Scrambled configuration after start must be ignored.
    start     = 1'b0;
    tick_div  = 16'd0;
    last_step = 4'd0;
    loop_en   = ~loop;
    checkOutput({tag, "_busy_c0"}, 32'(busy), 32'h1);
    checkOutput({tag, "_step_c0"}, 32'(step), 32'h0);
    for (int c = 1; c <= ncyc; c++) begin
      nextCycle();
      p = (c - 1) % 27;
      q = c % 27;
      if (p < 9) begin
        epa = 8'h40; epb = 8'h20;
      end else if (p < 14) begin
        epa = 8'h10; epb = 8'h00;
      end else begin
        epa = 8'h80; epb = 8'h80;
      end
      if (q < 9) estep = 4'd0;
      else if (q < 14) estep = 4'd1;
      else estep = 4'd2;
      if (!loop && c >= 27) begin
        epa = 8'h00; epb = 8'h00; estep = 4'd2;
      end
      checkOutput($sformatf("%s_pa_c%0d", tag, c), 32'(period_a), 32'(epa));
      checkOutput($sformatf("%s_pb_c%0d", tag, c), 32'(period_b), 32'(epb));
      checkOutput($sformatf("%s_step_c%0d", tag, c), 32'(step), 32'(estep));
      checkOutput($sformatf("%s_busy_c%0d", tag, c), 32'(busy),
                  32'(loop || c < 27));
      checkOutput($sformatf("%s_done_c%0d", tag, c), 32'(done),
                  32'(!loop && c == 27));
      if (inject && c == 5) begin
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 20'hFFFFF;
        start   = 1'b1;
      end else begin
        wr_en = 1'b0;
        start = 1'b0;
      end
    end
    clearInputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en     = 1'($urandom);
      wr_addr   = 4'($urandom);
      wr_data   = 20'($urandom);
      tick_div  = 16'($urandom);
      last_step = 4'($urandom);
      loop_en   = 1'($urandom);
      start     = 1'($urandom);
      stop      = 1'($urandom);
      nextCycle();
    end
    checkIdleZero("rst_hold");
    checkOutput("rst_hold_step", 32'(step), 32'h0);
    checkOutput("rst_hold_done", 32'(done), 32'h0);
    clearInputs();
    rst_n = 1'b1;
    nextCycle();
    checkIdleZero("rst_rel");
    checkOutput("rst_rel_step", 32'(step), 32'h0);
    checkOutput("rst_rel_done", 32'(done), 32'h0);
    runSingleStep("rst_mem", 8'h00, 8'h00);

    // Load the three-step pattern and play it once.
    applyStimulus(4'd0, 20'h14020);
    applyStimulus(4'd1, 20'h01000);
    applyStimulus(4'd2, 20'h28080);
    runPattern("single", 1'b0, 30, 1'b0);

    // Looping playback, then abort with stop.
    runPattern("loop", 1'b1, 60, 1'b0);
    stop = 1'b1;
    nextCycle();
    stop = 1'b0;
    checkIdleZero("loop_stop");
    checkOutput("loop_stop_done", 32'(done), 32'h0);
    nextCycle();
    checkOutput("loop_stop_done2", 32'(done), 32'h0);

    // Write and start during PLAY are ignored; entry 1 survives.
    runPattern("protect", 1'b0, 30, 1'b1);
    runPattern("rerun", 1'b0, 30, 1'b0);

    // start and stop together in IDLE: stays idle.
    start = 1'b1;
    stop  = 1'b1;
    nextCycle();
    nextCycle();
    clearInputs();
    checkIdleZero("prio_idle");

    // stop on the step-end cycle of a last_step=0 run: no done.
    tick_div  = 16'd3;
    last_step = 4'd0;
    start     = 1'b1;
    nextCycle();
    clearInputs();
    for (int c = 1; c <= 8; c++) begin
      nextCycle();
    end
    checkOutput("prio_pa_play", 32'(period_a), 32'h40);
    stop = 1'b1;
    nextCycle();
    stop = 1'b0;
    checkIdleZero("prio_stop");
    checkOutput("prio_stop_done", 32'(done), 32'h0);
    checkOutput("prio_stop_step", 32'(step), 32'h0);
    nextCycle();
    checkOutput("prio_stop_done2", 32'(done), 32'h0);

    // Write and start in the same IDLE cycle.
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_data = 20'h05566;
    runSingleStep("wr_start", 8'h55, 8'h66);

    // Async reset between edges during PLAY.
    tick_div  = 16'd3;
    last_step = 4'd0;
    start     = 1'b1;
    nextCycle();
    clearInputs();
    nextCycle();
    nextCycle();
    checkOutput("arst_pre_pa", 32'(period_a), 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdleZero("arst_async");
    checkOutput("arst_async_step", 32'(step), 32'h0);
    #2;
    rst_n = 1'b1;
    nextCycle();
    checkIdleZero("arst_rel");
    runSingleStep("arst_mem", 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/two_channel_note_sequencer.md
# two_channel_note_sequencer

Step sequencer that drives the two 8-bit half-period inputs of the two-channel square wave generator, so tunes play without a host CPU rewriting the periods. A 16-entry pattern memory holds per-step channel A period, channel B period and step duration. Once started, the block plays the steps in order at a programmable tempo and optionally loops. Its `period_a`/`period_b` outputs connect directly to the generator's channel A/B period inputs, where period 0 means silence.

## Interface
- `DEPTH_LOG2`, 4: log2 of pattern depth (16 steps).
- `TICK_WIDTH`, 16: width of tempo divider.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `wr_en` in 1: pattern write strobe; honoured only when `busy`=0.
- `wr_addr` in DEPTH_LOG2: pattern entry index.
- `wr_data` in 20: entry fields: {dur[3:0], per_a[7:0], per_b[7:0]}.
- `tick_div` in TICK_WIDTH: cycles per tick minus 1.
- `last_step` in DEPTH_LOG2: index of the final step played.
- `loop_en` in 1: 1 = wrap to step 0 after `last_step`, 0 = stop.
- `start` in 1: start request, level-sampled each cycle.
- `stop` in 1: abort request, level-sampled each cycle.
- `period_a` out 8: channel A half-period to the generator.
- `period_b` out 8: channel B half-period to the generator.
- `step` out DEPTH_LOG2: index of the current or last fetched step.
- `busy` out 1: high in FETCH or PLAY.
- `done` out 1: one-cycle pulse when a non-looping sequence completes.

## Operation
- States:
  - IDLE: silent, `busy`=0.
  - FETCH: 1 cycle, loads entry `step`.
  - PLAY: counts ticks.
- Pattern memory: 16×20 flops.
  - Cleared to 0 by reset.
  - Written in IDLE only.
  - `wr_en` in FETCH/PLAY is dropped with no effect.
- IDLE, `start`=1, `stop`=0:
  - Latch `tick_div`, `last_step`, `loop_en` into shadow registers.
  - `step`←0, go to FETCH.
  - Input changes after this edge have no effect until the next start.
- FETCH:
  - `period_a`←per_a, `period_b`←per_b.
  - dur_cnt←dur, tick_cnt←shadow tick_div.
  - Go to PLAY.
- PLAY, each cycle:
  - If tick_cnt≠0: tick_cnt−1.
  - Else if dur_cnt≠0: dur_cnt−1, tick_cnt←shadow tick_div.
  - Else step ends:
    - `step`≠last_step: `step`+1 (wraps modulo 16), go to FETCH.
    - `step`=last_step and loop: `step`←0, go to FETCH.
    - `step`=last_step and no loop: `period_a`/`period_b`←0, `done`=1 for one cycle, go to IDLE. `step` holds last_step.
- Step duration: (dur+1)·(tick_div+1) cycles in PLAY, plus 1 FETCH cycle. Periods hold their previous values during FETCH.
- `stop` in FETCH/PLAY:
  - Next edge: IDLE, periods←0, no `done` pulse, `step` holds.
  - `stop` beats `start` and beats step-end.
- `start` while `busy`: ignored.
- `start` and `wr_en` in the same IDLE cycle: write and start both take effect. The written entry is visible to the FETCH that follows.
- `last_step` > 15 cannot occur because of the port width. `last_step`=0 plays step 0 only.
- Arithmetic is unsigned. Counters never underflow: the zero checks come before any decrement.

## Timing
- Reset (async assert): `period_a`=0, `period_b`=0, `step`=0, `busy`=0, `done`=0, state IDLE, memory 0.
- Release is synchronous to `clk`.
- Reset asserted mid-play: outputs go to reset values immediately and the pattern is lost.
- `start` sampled at edge N: `busy`=1 after edge N. Step 0 periods appear after edge N+1.
- Step k+1 periods appear (dur_k+1)·(tick_div+1)+1 cycles after step k periods.
- `done` is high exactly in the cycle after the final PLAY edge, together with `busy`=0 and periods=0.
- `stop` at edge M: `busy`=0 and periods=0 after edge M.
- No combinational input-to-output paths. All outputs are registered.

## Test plan
- Reset check: hold `rst_n`=0 with random inputs, then release. All outputs read 0. Memory reads 0: start with last_step=0 plays period 0/0 and pulses `done`.
- Single pass: load entries 0..2 = {1,0x40,0x20}, {0,0x10,0x00}, {2,0x80,0x80}. Set tick_div=3, last_step=2, loop_en=0, pulse start. Periods change at cycles +2, +11, +16. `done` fires at cycle +28 and periods return to 0.
- Loop: same pattern with loop_en=1. After step 2, `step` returns to 0 and period_a=0x40 again 13 cycles after step 2 began. `done` never fires. Assert `stop`: next cycle busy=0 and periods=0.
- Protection: during PLAY, write wr_addr=1 with 0xFFFFF and pulse `start`. Playback timing and values are unchanged and entry 1 keeps its old value on the next run.
- Priority: assert `start` and `stop` together in IDLE; the block stays IDLE. Assert `stop` on the step-end cycle; it goes to IDLE with no `done`.
- Async reset mid-step: drop `rst_n` between clock edges during PLAY. Outputs are 0 before the next edge. After release, start with last_step=0 yields periods 0/0.
